// File: rtl/rs_fifo8_sp_if.sv
// rs_fifo8_sp_if: byte handshake bundle for the rs_fifo8_sp FIFO.
// The producer side (push) and consumer side (pop) share one interface.
// master = the environment driving pushes and accepting pops.
// slave  = the FIFO itself.
interface rs_fifo8_sp_if;
    logic [7:0] inData;
    logic       inValid;
    logic       inReady;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic [7:0] fill;

    modport master (
        output inData,
        output inValid,
        output outReady,
        input  inReady,
        input  outData,
        input  outValid,
        input  fill
    );

    modport slave (
        input  inData,
        input  inValid,
        input  outReady,
        output inReady,
        output outData,
        output outValid,
        output fill
    );
endinterface

// File: rtl/rs_fifo8_sp.sv
// rs_fifo8_sp: 8-bit valid/ready FIFO around one single-port,
// synchronous-read memory (maps onto RS_RAM8).
// Pointer and count arithmetic is plain 8-bit add/sub so it lands on
// RS_ADD8 / RS_DFF8 / RS_MUX8.
// Optional build macro RS_FIFO8_BYPASS_EN: when the FIFO is completely
// empty, a push loads the output register directly (one-cycle latency)
// and skips the memory. Without the macro every word goes through memory.
module rs_fifo8_sp #(
    parameter int DEPTH_LOG2 = 4,
    localparam int DEPTH = 1 << DEPTH_LOG2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rs_fifo8_sp_if.slave  io_fifo
);

    localparam int               PTR_W   = DEPTH_LOG2;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [7:0]       DEPTH8  = 8'(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [7:0]       r_memCnt;
    logic             r_rdPend;
    logic [7:0]       r_rdData;
    logic             r_outValid;
    logic [7:0]       r_outData;
    logic [7:0]       r_fill;

    logic             w_doRead;
    logic             w_inReady;
    logic             w_doWrite;
    logic             w_pop;
    logic             w_bypass;
    logic             w_memWrite;
    logic [PTR_W-1:0] w_memAddr;
    logic [7:0]       w_memCntNext;
    logic             w_rdPendNext;
    logic             w_outValidNext;
    logic [7:0]       w_outDataNext;
    logic [7:0]       w_fillNext;

    // Arbitration only looks at registered state, so OUT_READY never
    // reaches IN_READY combinationally; a read always wins the port.
    assign w_doRead  = (r_memCnt != 8'd0) && !r_rdPend && !r_outValid;
    assign w_inReady = !i_rst && (r_memCnt != DEPTH8) && !w_doRead;
    assign w_doWrite = io_fifo.inValid && w_inReady;
    assign w_pop     = r_outValid && io_fifo.outReady;

`ifdef RS_FIFO8_BYPASS_EN
    // An otherwise empty FIFO (output free or being freed) sends the
    // pushed byte straight to the output register.
    assign w_bypass = w_doWrite && (r_memCnt == 8'd0) && !r_rdPend
                      && (!r_outValid || w_pop);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_memWrite = w_doWrite && !w_bypass;
    assign w_memAddr  = w_doRead ? r_rdPtr : r_wrPtr;

    // Next-state values for the counters and the output stage.
    always_comb begin
        w_memCntNext = r_memCnt;
        if (w_memWrite) begin
            w_memCntNext = r_memCnt + 8'd1;
        end else if (w_doRead) begin
            w_memCntNext = r_memCnt - 8'd1;
        end

        w_rdPendNext = w_doRead;

        w_outValidNext = r_outValid;
        if (w_pop) begin
            w_outValidNext = 1'b0;
        end
        if (r_rdPend || w_bypass) begin
            w_outValidNext = 1'b1;
        end

        w_outDataNext = r_outData;
        if (r_rdPend) begin
            w_outDataNext = r_rdData;
        end
`ifdef RS_FIFO8_BYPASS_EN
        if (w_bypass) begin
            w_outDataNext = io_fifo.inData;
        end
`endif

        w_fillNext = w_memCntNext + {7'd0, w_rdPendNext} + {7'd0, w_outValidNext};
    end

    // Single-port memory: one write or one registered read per cycle.
    always_ff @(posedge i_clk) begin
        if (w_memWrite) begin
            r_mem[w_memAddr] <= io_fifo.inData;
        end else begin
            r_rdData <= r_mem[w_memAddr];
        end
    end

    // Pointers, occupancy and the registered output stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_memCnt   <= 8'd0;
            r_rdPend   <= 1'b0;
            r_outValid <= 1'b0;
            r_outData  <= 8'h00;
            r_fill     <= 8'd0;
        end else begin
            if (w_memWrite) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doRead) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            r_memCnt   <= w_memCntNext;
            r_rdPend   <= w_rdPendNext;
            r_outValid <= w_outValidNext;
            r_outData  <= w_outDataNext;
            r_fill     <= w_fillNext;
        end
    end

    assign io_fifo.inReady  = w_inReady;
    assign io_fifo.outData  = r_outData;
    assign io_fifo.outValid = r_outValid;
    assign io_fifo.fill     = r_fill;

endmodule

// File: tb/tb_rs_fifo8_sp.sv
// tb_rs_fifo8_sp: randomized and directed bench for rs_fifo8_sp.
// A queue holds every word the FIFO has accepted and not yet handed out;
// FILL, output data order and handshake limits are judged against it.
// Honors RS_FIFO8_BYPASS_EN for the first-word latency expectation.
module tb_rs_fifo8_sp;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef RS_FIFO8_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    rs_fifo8_sp_if fifoIf();

    rs_fifo8_sp #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .io_fifo (fifoIf.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int         checkCount = 0;
    int         errorCount = 0;
    logic [7:0] model[$];
    int         gapCnt     = 0;
    int         acceptCnt  = 0;
    int         popCnt     = 0;
    logic       lastAccept = 1'b0;
    logic       lastPop    = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive, sample handshakes mid-cycle, update the
    // reference queue, then check FILL just after the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        fifoIf.inValid  = v;
        fifoIf.inData   = d;
        fifoIf.outReady = r;
        #1;
        lastAccept = v && fifoIf.inReady;
        lastPop    = fifoIf.outValid && r;
        if (model.size() == 0) begin
            gapCnt = 0;
            checkOutput("spuriousValid", 32'(fifoIf.outValid), 32'(0));
        end else if (fifoIf.outValid) begin
            gapCnt = 0;
            checkOutput("data", 32'(fifoIf.outData), 32'(model[0]));
        end else begin
            gapCnt++;
            checkOutput("wordGapTooLong", 32'(gapCnt > 2), 32'(0));
        end
        if (model.size() == DEPTH + 1) begin
            checkOutput("fullReady", 32'(fifoIf.inReady), 32'(0));
        end
        if (lastPop) begin
            void'(model.pop_front());
            popCnt++;
        end
        if (lastAccept) begin
            model.push_back(d);
            acceptCnt++;
        end
        @(posedge clk);
        #1;
        checkOutput("fill", 32'(fifoIf.fill), 32'(model.size()));
    endtask

    task automatic applyReset();
        fifoIf.inValid  = 1'b0;
        fifoIf.inData   = 8'h00;
        fifoIf.outReady = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rstReady", 32'(fifoIf.inReady), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        model.delete();
        gapCnt = 0;
        checkOutput("rstValid", 32'(fifoIf.outValid), 32'(0));
        checkOutput("rstFill", 32'(fifoIf.fill), 32'(0));
        checkOutput("rstData", 32'(fifoIf.outData), 32'(0));
        checkOutput("postRstReady", 32'(fifoIf.inReady), 32'(1));
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && model.size() != 0; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("drainFill", 32'(fifoIf.fill), 32'(0));
        checkOutput("drainValid", 32'(fifoIf.outValid), 32'(0));
    endtask

    task automatic pushWords(input int count, input logic [7:0] base);
        acceptCnt = 0;
        for (int k = 0; k < 60 && acceptCnt < count; k++) begin
            applyStimulus(1'b1, base + 8'(acceptCnt), 1'b0);
        end
        for (int k = 0; k < 10 && !fifoIf.outValid; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
        end
        checkOutput("pushCount", 32'(acceptCnt), 32'(count));
    endtask

    // Hard stop in case something never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int idx;
        fifoIf.inValid  = 1'b0;
        fifoIf.inData   = 8'h00;
        fifoIf.outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyReset();

        // First-word latency with 0x5A.
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("latAccept", 32'(lastAccept), 32'(1));
        checkOutput("lat1Valid", 32'(fifoIf.outValid), 32'(BYPASS));
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("lat2Valid", 32'(fifoIf.outValid), 32'(BYPASS));
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("lat3Valid", 32'(fifoIf.outValid), 32'(1));
        checkOutput("lat3Data", 32'(fifoIf.outData), 32'(8'h5A));
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("popValid", 32'(fifoIf.outValid), 32'(0));

        // Fill to capacity with the consumer stalled.
        acceptCnt = 0;
        for (int k = 0; k < 25; k++) begin
            applyStimulus(1'b1, 8'(acceptCnt), 1'b0);
        end
        checkOutput("acceptedWords", 32'(acceptCnt), 32'(DEPTH + 1));
        checkOutput("fullFill", 32'(fifoIf.fill), 32'(DEPTH + 1));
        checkOutput("fullInReady", 32'(fifoIf.inReady), 32'(0));
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            checkOutput("heldData", 32'(fifoIf.outData), 32'(8'h00));
            checkOutput("heldValid", 32'(fifoIf.outValid), 32'(1));
        end
        drain();

        // Stream 40 words through the pointer wraps.
        idx = 0;
        popCnt = 0;
        for (int k = 0; k < 600 && (idx < 40 || model.size() != 0); k++) begin
            applyStimulus(idx < 40, 8'h10 + 8'(idx), 1'b1);
            if (lastAccept) idx++;
        end
        checkOutput("streamPops", 32'(popCnt), 32'(40));

        // Reset while a read is in flight.
        pushWords(6, 8'hC0);
        checkOutput("fill6", 32'(fifoIf.fill), 32'(6));
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("fill5", 32'(fifoIf.fill), 32'(5));
        applyReset();
        applyStimulus(1'b1, 8'hA5, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("afterRstData", 32'(fifoIf.outData), 32'(8'hA5));
        drain();

        // Simultaneous push and pop at FILL=3.
        pushWords(3, 8'h31);
        checkOutput("fill3", 32'(fifoIf.fill), 32'(3));
        applyStimulus(1'b1, 8'h22, 1'b1);
        checkOutput("simulAccept", 32'(lastAccept), 32'(1));
        checkOutput("simulPop", 32'(lastPop), 32'(1));
        checkOutput("simulFill", 32'(fifoIf.fill), 32'(3));
        drain();

        // Random traffic: slow consumer, then fast consumer.
        for (int k = 0; k < 300; k++) begin
            applyStimulus($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) == 0);
        end
        for (int k = 0; k < 300; k++) begin
            applyStimulus($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/rs_fifo8_sp.md
Name: rs_fifo8_sp

Overview:
- 8-bit valid/ready FIFO built around one single-port, synchronous-read memory.
- The memory is written so that the flow's BRAM mapping lands it on RS_RAM8.
- All pointer and count arithmetic is 8-bit add/sub, so it maps onto RS_ADD8, RS_DFF8 and RS_MUX8.
- Sits between a byte producer (e.g. an input decoder) and a consumer datapath. It decouples them across the slow redstone clock.

Parameters:
- DEPTH_LOG2, 4, log2 of the memory depth. Legal range 1..7, so DEPTH = 2..128.
- DEPTH, 1<<DEPTH_LOG2, derived. Not overridden.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- IN_DATA  in  8  push data.
- IN_VALID  in  1  producer has data.
- IN_READY  out  1  FIFO accepts data this cycle.
- OUT_DATA  out  8  pop data, registered.
- OUT_VALID  out  1  OUT_DATA holds a valid word.
- OUT_READY  in  1  consumer takes the word.
- FILL  out  8  total words held: memory + pending read + output register.

Behaviour:
- Clocking/reset:
  - One clock, CLK. RST is synchronous and active-high, sampled on the CLK rising edge.
  - Reset clears: wr_ptr=0, rd_ptr=0, mem_cnt=0, rd_pend=0, OUT_VALID=0, OUT_DATA=0x00, FILL=0.
  - Memory contents are not reset.
  - IN_READY is forced 0 while RST=1.
- Storage:
  - Memory is DEPTH x 8, single port, one access (read or write) per cycle.
  - Synchronous read: data is available the cycle after the read is issued.
  - Address = pointer zero-extended to 8 bits.
- Arbitration, using registered state only (no combinational path from OUT_READY to IN_READY):
  - do_read = (mem_cnt != 0) && !rd_pend && !OUT_VALID.
  - do_write = IN_VALID && IN_READY.
  - IN_READY = !RST && (mem_cnt != DEPTH) && !do_read_cond. Read has priority over write.
- Push: on do_write
  - mem[wr_ptr] <= IN_DATA.
  - wr_ptr increments, wrapping DEPTH-1 -> 0.
  - mem_cnt increments.
- Read: on do_read
  - Address = rd_ptr; rd_ptr increments (wraps); mem_cnt decrements.
  - rd_pend <= 1.
- Next cycle after rd_pend=1:
  - OUT_DATA <= memory data; OUT_VALID <= 1; rd_pend <= 0.
- Pop:
  - OUT_VALID && OUT_READY -> OUT_VALID <= 0 next cycle.
  - OUT_DATA holds its value until replaced.
- Latency:
  - Push accepted at cycle t into an empty FIFO -> read at t+1 -> OUT_VALID=1 at t+2.
  - Steady-state throughput is 1 word per 3 cycles: read, present, pop.
- FILL = mem_cnt + rd_pend + OUT_VALID, registered, 8-bit. Maximum is DEPTH+1.
- Boundary cases:
  - Full (mem_cnt==DEPTH): IN_READY=0; IN_DATA ignored.
  - Empty: OUT_VALID stays 0; OUT_DATA retains its last value.
  - Backpressure: while OUT_VALID && !OUT_READY, OUT_DATA and OUT_VALID are stable.
  - IN_VALID may drop without acceptance.
  - Simultaneous push and pop in the same cycle are both honoured; FILL is unchanged.
  - Reset mid-operation discards all data, including an in-flight read. Next cycle: OUT_VALID=0, FILL=0.
  - Pointer wrap is transparent: ordering is strict FIFO.

Optional Feature:
- Macro: RS_FIFO8_BYPASS_EN.
- Defined:
  - When mem_cnt==0, rd_pend==0, OUT_VALID==0 (or OUT_VALID && OUT_READY this cycle), a push loads OUT_DATA directly.
  - In that case OUT_VALID=1 at t+1 and the memory is not written.
  - IN_READY rules are unchanged.
- Undefined:
  - All pushes go through memory; first-word latency is 2 cycles.
  - No direct IN_DATA->OUT_DATA mux is built.

Test Plan:
- Reset, then push 0x5A at t -> OUT_VALID=1, OUT_DATA=0x5A at t+2; FILL=1; after OUT_READY pulse FILL=0, OUT_VALID=0.
- DEPTH_LOG2=4, OUT_READY=0, IN_VALID=1 with data 0x00,0x01,... -> exactly 17 words accepted, IN_READY=0, FILL=17, OUT_DATA=0x00 held stable for 10 cycles.
- Stream 40 words 0x10..0x37 with OUT_READY=1 -> outputs arrive in order 0x10..0x37 across two pointer wraps; no drop or duplicate.
- FILL=5, assert RST one cycle while a read is pending -> next cycle OUT_VALID=0, FILL=0, IN_READY=1; the next push 0xA5 is the first word out.
- Simultaneous push 0x22 and pop while FILL=3 -> FILL stays 3; 0x22 emerges after the three older words.
- RS_FIFO8_BYPASS_EN defined, empty FIFO, push 0x7E at t -> OUT_VALID=1, OUT_DATA=0x7E at t+1, FILL=1, memory not written.
